// File: rtl/wisc_mem_pkg.sv
// Shared types and defaults for the unified main-memory arbiter.
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_MEM_LATENCY     = 4;

  // Byte-offset bits of a block of 16-bit words.
  function automatic int block_off_bits(input int words);
    return $clog2(2 * words);
  endfunction

  localparam int DEF_BLOCK_OFF_BITS = $clog2(2 * DEF_WORDS_PER_BLOCK);

endpackage

// File: rtl/block_fill_seq.sv
// Block-fill sequencer: block base register, issue/receive counters, word
// address generation and detection of the last returned word.
module block_fill_seq
  import wisc_mem_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int WPB    = DEF_WORDS_PER_BLOCK,
  parameter int IW     = $clog2(WPB),
  parameter int CW     = IW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [AWIDTH-1:0] addr,
  input  logic              active,
  input  logic              rvalid,
  output logic              issue_en,
  output logic [AWIDTH-1:0] issue_addr,
  output logic [IW-1:0]     recv_idx,
  output logic              last_word
);

  localparam int OFF = block_off_bits(WPB);
  localparam logic [AWIDTH-1:0] OFF_MASK = AWIDTH'((1 << OFF) - 1);

  logic [AWIDTH-1:0] base_q;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     recv_cnt;

  // Issue counter saturates at WPB so mem_en drops after the last read.
  assign issue_en   = active && (issue_cnt < CW'(WPB));
  assign issue_addr = base_q + AWIDTH'({issue_cnt, 1'b0});
  assign recv_idx   = recv_cnt[IW-1:0];
  assign last_word  = active && rvalid && (recv_cnt == CW'(WPB - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_q    <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      if (load) begin
        base_q <= addr & ~OFF_MASK;
      end
      if (last_word) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        if (issue_en) begin
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (active && rvalid) begin
          recv_cnt <= recv_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported main memory between I-side fills and D-side
// fills/writes. Define MEM_ARB_ROUND_ROBIN_EN for round-robin on collisions.
module mem_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int AWIDTH          = 16,
  parameter int DWIDTH          = 16,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int MEM_LATENCY     = DEF_MEM_LATENCY
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_req,
  input  logic [AWIDTH-1:0]                  i_addr,
  output logic                               i_grant,
  input  logic                               d_req,
  input  logic                               d_wr,
  input  logic [AWIDTH-1:0]                  d_addr,
  input  logic [DWIDTH-1:0]                  d_wdata,
  output logic                               d_grant,
  output logic                               fill_valid,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_idx,
  output logic [DWIDTH-1:0]                  fill_data,
  output logic                               i_done,
  output logic                               d_done,
  output logic                               mem_en,
  output logic                               mem_wr,
  output logic [AWIDTH-1:0]                  mem_addr,
  output logic [DWIDTH-1:0]                  mem_wdata,
  input  logic [DWIDTH-1:0]                  mem_rdata,
  input  logic                               mem_rvalid,
  output logic [1:0]                         dbg_state
);

  // Requests are level-held by the requester until its done pulse; there is
  // no valid/ready back-pressure, the grant/done pair is the whole handshake.
  localparam int IW = $clog2(WORDS_PER_BLOCK);

  if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 ||
      MEM_LATENCY < 1) begin : g_cfg_check
    $error("mem_arbiter: WORDS_PER_BLOCK must be a power of two >= 2, MEM_LATENCY >= 1");
  end

  arb_state_t state_q, state_d;
  owner_t     owner_q, owner_d;

  logic              seq_load;
  logic [AWIDTH-1:0] load_addr;
  logic              seq_issue_en;
  logic [AWIDTH-1:0] seq_issue_addr;
  logic [IW-1:0]     seq_recv_idx;
  logic              seq_last;
  logic              d_first;
  logic              d_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_owner_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_owner_q <= OWN_I;
    end else if (state_q == ST_IDLE && state_d != ST_IDLE) begin
      last_owner_q <= owner_d;
    end
  end

  assign d_first = (last_owner_q == OWN_I);
`else
  assign d_first = 1'b1;
`endif

  // A lone requester always wins; d_first only settles collisions.
  assign d_win = d_req && (d_first || !i_req);

  block_fill_seq #(
    .AWIDTH (AWIDTH),
    .WPB    (WORDS_PER_BLOCK)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .load       (seq_load),
    .addr       (load_addr),
    .active     (state_q == ST_FILL),
    .rvalid     (mem_rvalid),
    .issue_en   (seq_issue_en),
    .issue_addr (seq_issue_addr),
    .recv_idx   (seq_recv_idx),
    .last_word  (seq_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    seq_load   = 1'b0;
    load_addr  = i_addr;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_valid = 1'b0;
    fill_idx   = '0;
    fill_data  = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (d_win) begin
          owner_d   = OWN_D;
          load_addr = d_addr;
          if (d_wr) begin
            state_d = ST_WRITE;
          end else begin
            state_d  = ST_FILL;
            seq_load = 1'b1;
          end
        end else if (i_req) begin
          owner_d  = OWN_I;
          state_d  = ST_FILL;
          seq_load = 1'b1;
        end
      end
      ST_FILL: begin
        mem_en = seq_issue_en;
        if (seq_issue_en) begin
          mem_addr = seq_issue_addr;
        end
        if (mem_rvalid) begin
          fill_valid = 1'b1;
          fill_idx   = seq_recv_idx;
          fill_data  = mem_rdata;
        end
        if (seq_last) begin
          i_done  = (owner_q == OWN_I);
          d_done  = (owner_q == OWN_D);
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_done    = 1'b1;
        state_d   = ST_IDLE;
        owner_d   = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign i_grant   = (state_q != ST_IDLE) && (owner_q == OWN_I);
  assign d_grant   = (state_q != ST_IDLE) && (owner_q == OWN_D);
  assign dbg_state = state_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one multi-cycle, single-ported main memory between the instruction-side miss path and the data-side miss/write path.
- Sequences 8-word cache block fills as pipelined reads, and single-word data writes.
- Sits between the fetch-stage and mem-stage cache controllers and the unified main memory.
- Lets the CPU move from split instruction/data memories to cached access of one memory.

Parameters:
- AWIDTH, 16, byte-address width.
- DWIDTH, 16, word width.
- WORDS_PER_BLOCK, 8, words per cache block; power of two, at least 2.
- MEM_LATENCY, 4, cycles from a read-enable cycle to its mem_rvalid cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- i_req  in  1  instruction-side fill request; held until i_done.
- i_addr  in  AWIDTH  instruction miss byte address.
- i_grant  out  1  instruction side owns memory.
- d_req  in  1  data-side request; held until d_done.
- d_wr  in  1  1 = single-word write, 0 = block fill.
- d_addr  in  AWIDTH  data byte address.
- d_wdata  in  DWIDTH  write data.
- d_grant  out  1  data side owns memory.
- fill_valid  out  1  fill_data/fill_idx valid for the current owner.
- fill_idx  out  log2(WORDS_PER_BLOCK)  word index within the block.
- fill_data  out  DWIDTH  returned word.
- i_done  out  1  one-cycle pulse: instruction fill complete.
- d_done  out  1  one-cycle pulse: data fill or write complete.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write.
- mem_addr  out  AWIDTH  memory byte address.
- mem_wdata  out  DWIDTH  memory write data.
- mem_rdata  in  DWIDTH  memory read data.
- mem_rvalid  in  1  mem_rdata valid.

Behaviour:
- States: IDLE, FILL, WRITE.
- Reset values:
  - state=IDLE; owner=none; issue_cnt=0; recv_cnt=0.
  - All outputs 0, including mem_addr, mem_wdata and fill_data.
- Arbitration in IDLE:
  - Requests are sampled in IDLE only.
  - The data side has fixed priority over the instruction side.
  - d_req&d_wr -> WRITE.
  - d_req&!d_wr -> FILL with owner=D.
  - else i_req -> FILL with owner=I.
  - The request address is registered on the transition. Base = addr with its low log2(2*WORDS_PER_BLOCK) bits cleared.
- Grant:
  - Owner's grant is high from the first cycle in FILL/WRITE through the cycle its done pulses.
  - Grants are mutually exclusive.
- WRITE:
  - Lasts exactly one cycle.
  - mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata.
  - d_done=1 in the same cycle; next state is IDLE.
- FILL issue:
  - In FILL cycle k (k=0..WORDS_PER_BLOCK-1): mem_en=1, mem_wr=0, mem_addr=base+2k.
  - issue_cnt saturates; mem_en=0 after the last issue.
- FILL receive:
  - On each mem_rvalid: fill_valid=1, fill_idx=recv_cnt, fill_data=mem_rdata (combinational pass-through); recv_cnt increments.
  - On the rvalid where recv_cnt==WORDS_PER_BLOCK-1: owner done=1, next state IDLE, counters cleared.
- Latency with defaults:
  - Request seen in IDLE at cycle T.
  - Issues at T+1..T+8; data at T+5..T+12.
  - done at T+12; IDLE at T+13.
  - Earliest new grant is at T+14 (IDLE consumes one cycle).
- Requester drops its req mid-operation: the operation completes anyway; there is no abort.
- mem_rvalid while in IDLE or WRITE is ignored (no fill_valid).
- Reset mid-FILL:
  - Returns to IDLE with counters cleared.
  - Main memory shares rst, so in-flight reads are discarded.
- Simultaneous i_req and d_req: the data side is served first. The instruction request waits in IDLE re-arbitration after d_done.
- fill_idx wraps naturally at WORDS_PER_BLOCK; counter widths are log2(WORDS_PER_BLOCK)+1.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_owner flop (reset = I) is added.
  - When i_req and d_req are both pending in IDLE, the side that was not last_owner wins.
  - A single requester always wins.
- Undefined: fixed data-side priority as above; no extra flop.

Decomposition:
- Package wisc_mem_pkg:
  - State enum (IDLE/FILL/WRITE).
  - Owner encoding (NONE/I/D).
  - WORDS_PER_BLOCK and MEM_LATENCY defaults.
  - Block-offset-bits constant.
- Sub-module block_fill_seq holds issue_cnt, recv_cnt, address generation and the last-word detect. mem_arbiter keeps the FSM, arbitration and grant/done muxing.

Test Plan:
- Reset: hold rst=0 three cycles with i_req=1 -> all outputs 0; after release, i_grant rises the cycle after the first IDLE sample.
- I fill: i_req, i_addr=0x1236 -> mem_addr 0x1230,0x1232,...,0x123E on consecutive cycles. The model returns 0xA000+k; fill_idx 0..7 and fill_data match; i_done pulses once at T+12.
- Collision: i_req and d_req (d_wr=0, d_addr=0x4000) asserted together -> D block filled first, then I fill. Grants never overlap. With MEM_ARB_ROUND_ROBIN_EN and last_owner=D, I goes first.
- Write: d_req, d_wr=1, d_addr=0x0102, d_wdata=0xBEEF -> one cycle with mem_en=1, mem_wr=1, addr 0x0102, data 0xBEEF, d_done=1; back to IDLE.
- Reset mid-fill: rst=0 after 3 words returned -> IDLE, then new i_req fill restarts at fill_idx 0 with correct 8 words.
- Spurious rvalid: mem_rvalid=1 while in IDLE -> fill_valid stays 0 and no done pulses.
